// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller states, frame edge numbering and command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SETUP,
    SEND,
    WAIT_IDLE
  } ps2_state_e;

  // Falling edges are numbered from 1 after clk release: 1-8 data, 9 parity, 10 stop, 11 ACK.
  localparam logic [3:0] DATA_EDGES  = 4'd8;
  localparam logic [3:0] PARITY_EDGE = 4'd9;
  localparam logic [3:0] STOP_EDGE   = 4'd10;
  localparam logic [3:0] FRAME_EDGES = 4'd11;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser plus falling-edge detect for the raw PS/2 clk and data lines.
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic clk_raw_i,
  input  logic data_raw_i,
  output logic sync_clk_o,
  output logic sync_data_o,
  output logic clk_fall_o,
  output logic data_fall_o
);

  logic [1:0] clk_ff_q, data_ff_q;
  logic       clk_prev_q, data_prev_q;

  // Idle lines are high, so reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_ff_q    <= 2'b11;
      data_ff_q   <= 2'b11;
      clk_prev_q  <= 1'b1;
      data_prev_q <= 1'b1;
    end else begin
      clk_ff_q    <= {clk_ff_q[0], clk_raw_i};
      data_ff_q   <= {data_ff_q[0], data_raw_i};
      clk_prev_q  <= clk_ff_q[1];
      data_prev_q <= data_ff_q[1];
    end
  end

  assign sync_clk_o  = clk_ff_q[1];
  assign sync_data_o = data_ff_q[1];
  assign clk_fall_o  = clk_prev_q & ~clk_ff_q[1];
  assign data_fall_o = data_prev_q & ~data_ff_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, clocked-out frame, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int SETUP_CYCLES   = 200,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int MAX_IS = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int MAX_C  = (MAX_IS > TIMEOUT_CYCLES) ? MAX_IS : TIMEOUT_CYCLES;
  localparam int CW     = $clog2(MAX_C) + 1;

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LIM  = CW'(TIMEOUT_CYCLES);

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          data_oe_q, data_oe_d;
  logic          ack_q, ack_d;

  logic sync_clk, sync_data, clk_fall, data_fall_unused;
  logic run, done_w, tmo_w;

  ps2_line_sync u_sync (
    .clk         (clk),
    .reset       (reset),
    .clk_raw_i   (ps2_clk_in),
    .data_raw_i  (ps2_data_in),
    .sync_clk_o  (sync_clk),
    .sync_data_o (sync_data),
    .clk_fall_o  (clk_fall),
    .data_fall_o (data_fall_unused)
  );

  assign run     = (state_q == SEND) || (state_q == WAIT_IDLE);
  assign done_w  = (state_q == WAIT_IDLE) && sync_clk && sync_data;
  // A completing frame wins over a coincident timeout so done and error stay exclusive.
  assign tmo_w   = run && (cnt_q == TMO_LIM) && !done_w;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_oe_d = data_oe_q;
    ack_d     = ack_q;
    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d = tx_data;
          par_d   = ~^tx_data;
          ack_d   = 1'b0;
          cnt_d   = '0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = SETUP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SETUP: begin
        if (cnt_q == SET_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = SEND;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SEND: begin
        cnt_d = cnt_inc;
        if (tmo_w) begin
          data_oe_d = 1'b0;
          ack_d     = 1'b0;
          state_d   = IDLE;
        end else if (clk_fall) begin
          bit_d = (bit_q == 4'hF) ? bit_q : bit_q + 4'd1;
          if (bit_d <= DATA_EDGES) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end else if (bit_d == PARITY_EDGE) begin
            data_oe_d = ~par_q;
          end else if (bit_d == STOP_EDGE) begin
            data_oe_d = 1'b0;
          end else if (bit_d == FRAME_EDGES) begin
            ack_d   = ~sync_data;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = cnt_inc;
        if (done_w) begin
          state_d = IDLE;
        end else if (tmo_w) begin
          data_oe_d = 1'b0;
          ack_d     = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_oe_q <= data_oe_d;
      ack_q     <= ack_d;
    end
  end

  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign ps2_clk_oe  = (state_q == INHIBIT) || (state_q == SETUP);
  // Gate with the timeout so both lines are already released in the error cycle.
  assign ps2_data_oe = data_oe_q && !tmo_w;
  assign done        = done_w;
  assign error       = tmo_w;
  assign ack_ok      = ack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model plus a cycle-level timing/frame model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 100;
  localparam int SET  = 10;
  localparam int TMO  = 5000;
  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, error;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk_pull = 1'b0, dev_data_pull = 1'b0;

  assign ps2_clk_in  = !(ps2_clk_oe || dev_clk_pull);
  assign ps2_data_in = !(ps2_data_oe || dev_data_pull);

  int vec = 0, miss = 0;
  bit m_busy = 0, m_end = 0, m_ack = 0;
  int since = 0;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .ack_ok(ack_ok), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (($countones(b) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Timing model: cycles since acceptance decide what the lines must be doing.
  always begin
    @(posedge clk);
    if (!reset) begin
      m_busy = 0; m_end = 0;
    end else if (m_busy) begin
      since++;
      if (m_end) m_busy = 0;
      m_end = 0;
    end else if (tx_valid) begin
      m_busy = 1; since = 1;
    end
    #1;
    chk("busy", busy, m_busy);
    chk("tx_ready", tx_ready, !m_busy);
    chk("done_err_excl", done & error, 0);
    if (!m_busy) begin
      chk("idle_clk_oe", ps2_clk_oe, 0);
      chk("idle_data_oe", ps2_data_oe, 0);
      chk("idle_done", done, 0);
      chk("idle_error", error, 0);
    end else begin
      if (since <= INH) begin
        chk("inh_clk_oe", ps2_clk_oe, 1);
        chk("inh_data_oe", ps2_data_oe, 0);
      end else if (since <= INH + SET) begin
        chk("setup_clk_oe", ps2_clk_oe, 1);
        chk("setup_data_oe", ps2_data_oe, 1);
      end else begin
        chk("send_clk_oe", ps2_clk_oe, 0);
      end
      if (done) begin
        chk("done_ack_ok", ack_ok, m_ack);
        m_end = 1;
      end
      if (error) begin
        chk("tmo_at", since, INH + SET + 1 + TMO);
        chk("tmo_data_oe", ps2_data_oe, 0);
        chk("tmo_ack_ok", ack_ok, 0);
        m_end = 1;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    tx_data = b; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  // Device: waits for clk release, samples start bit, then clocks n_edges falling edges.
  task automatic dev_frame(input int n_edges, input bit do_ack, output logic [10:0] fr,
                           output int n_inh, output int n_set);
    int guard;
    fr = '0; n_inh = 0; n_set = 0; guard = 0;
    while (ps2_clk_oe && guard < 1000) begin
      if (ps2_data_oe) n_set++; else n_inh++;
      tick(); guard++;
    end
    chk("release_seen", guard < 1000, 1);
    fr[0] = ps2_data_in;
    repeat (HALF) tick();
    for (int k = 1; k <= n_edges; k++) begin
      dev_clk_pull = 1'b1;
      repeat (HALF) tick();
      if (k == n_edges && n_edges < 11) return;
      dev_clk_pull = 1'b0;
      if (k == 11) begin
        dev_data_pull = 1'b0;
        return;
      end
      fr[k] = ps2_data_in;
      if (k == 10 && do_ack) dev_data_pull = 1'b1;
      repeat (HALF) tick();
    end
  endtask

  task automatic wait_done(input string nm, input bit exp_ack);
    int g;
    g = 0;
    while (!done && g < 400) begin tick(); g++; end
    chk({nm, "_done_seen"}, done, 1);
    chk({nm, "_ack"}, ack_ok, exp_ack);
    chk({nm, "_err"}, error, 0);
    chk({nm, "_busy_in_done"}, busy, 1);
    tick();
    chk({nm, "_done_1cyc"}, done, 0);
    chk({nm, "_busy_fell"}, busy, 0);
  endtask

  initial begin
    logic [10:0] fr;
    int ni, ns, g, rel;
    bit seen_done;

    repeat (3) tick();
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_ok", ack_ok, 0);
    chk("rst_error", error, 0);
    reset = 1'b1;
    repeat (2) tick();

    // 0xF4 with ACK, plus inhibit/setup lengths
    m_ack = 1;
    send(CMD_ENABLE);
    dev_frame(11, 1, fr, ni, ns);
    chk("inhibit_len", ni, INH);
    chk("setup_len", ns, SET);
    chk("f4_frame_lit", fr, 11'b10111101000);
    chk("f4_frame_model", fr, frame_of(CMD_ENABLE));
    wait_done("f4", 1);
    tick();

    // 0x00, then 0xFF requested in the done cycle
    send(8'h00);
    dev_frame(11, 1, fr, ni, ns);
    chk("00_frame_lit", fr, 11'b11000000000);
    chk("00_frame_model", fr, frame_of(8'h00));
    g = 0;
    while (!done && g < 400) begin tick(); g++; end
    chk("00_done_seen", done, 1);
    chk("00_ack", ack_ok, 1);
    tx_data = 8'hFF; tx_valid = 1'b1;
    tick();
    chk("b2b_idle_first", tx_ready, 1);
    tick();
    tx_valid = 1'b0;
    chk("b2b_accepted", busy, 1);
    dev_frame(11, 1, fr, ni, ns);
    chk("ff_frame_lit", fr, 11'b11111111110);
    chk("ff_frame_model", fr, frame_of(8'hFF));
    wait_done("ff", 1);
    tick();

    // Device never drives ACK
    m_ack = 0;
    send(CMD_SET_LEDS);
    dev_frame(11, 0, fr, ni, ns);
    chk("ed_frame_model", fr, frame_of(CMD_SET_LEDS));
    wait_done("noack", 0);
    tick();

    // Device never clocks
    send(CMD_RESET);
    rel = -1; seen_done = 0; g = 0;
    while (!error && g < 6000) begin
      tick(); g++;
      if (rel < 0 && !ps2_clk_oe) rel = g;
      if (done) seen_done = 1;
    end
    chk("tmo_error_seen", error, 1);
    chk("tmo_len", g - rel, TMO);
    chk("tmo_clk_oe", ps2_clk_oe, 0);
    chk("tmo_data_oe_now", ps2_data_oe, 0);
    chk("tmo_no_done", seen_done, 0);
    tick();
    chk("tmo_ready_after", tx_ready, 1);
    chk("tmo_err_1cyc", error, 0);
    chk("tmo_data_oe_after", ps2_data_oe, 0);

    // Reset mid-frame after edge 5
    m_ack = 1;
    send(CMD_ENABLE);
    dev_frame(5, 1, fr, ni, ns);
    #3 reset = 1'b0;
    #1;
    chk("midrst_clk_oe", ps2_clk_oe, 0);
    chk("midrst_data_oe", ps2_data_oe, 0);
    chk("midrst_busy", busy, 0);
    dev_clk_pull = 1'b0; dev_data_pull = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("midrst_ready", tx_ready, 1);
    send(CMD_RESET);
    dev_frame(11, 1, fr, ni, ns);
    chk("post_rst_ff_frame", fr, 11'b11111111110);
    wait_done("post_rst", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miss);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (for example 0xF4 enable-reporting or 0xFF reset) to the keyboard or mouse on the board's ps2_clk/ps2_data pair, and reports the device acknowledge. It sits beside the PS/2 receiver in the VGA top level and drives the lines open-drain through top-level tri-states (line = oe ? 0 : 'bz). The receiver ignores line activity while busy=1.

Parameters:
INHIBIT_CYCLES, 12000, clock cycles ps2_clk is held low before the request (120 us at 100 MHz).
SETUP_CYCLES, 200, cycles data is held low with clk still low before clk is released (2 us).
TIMEOUT_CYCLES, 2000000, cycles allowed from clk release to frame completion (20 ms).

Ports:
clk  in  1  100 MHz system clock
reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
tx_data  in  8  byte to send
tx_valid  in  1  request; accepted when tx_valid & tx_ready
tx_ready  out  1  high only in IDLE
ps2_clk_in  in  1  raw ps2_clk line level (async)
ps2_data_in  in  1  raw ps2_data line level (async)
ps2_clk_oe  out  1  1 = pull ps2_clk low
ps2_data_oe  out  1  1 = pull ps2_data low
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at frame end
ack_ok  out  1  valid with done; 1 = device ACK seen
error  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, reset=0): state IDLE; ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, done=0, ack_ok=0, error=0. Lines are released immediately, including mid-frame.
- Both inputs pass through 2-FF synchronisers. A falling edge is sync_clk previous=1, current=0. Edge-to-action latency is 3 clk cycles.
- IDLE: on tx_valid, latch tx_data into an 8-bit shift register and set parity = ~^tx_data (odd parity). Go to INHIBIT. tx_valid is ignored while busy.
- INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES, then go to SETUP.
- SETUP: clk_oe=1, data_oe=1 (start bit 0) for SETUP_CYCLES, then go to SEND. Clear bit_cnt (4 bits) and the timeout counter.
- SEND: clk_oe=0. On each falling edge, bit_cnt increments:
  - edges 1-8: data_oe = ~shift[0], then shift right (LSB first);
  - edge 9: data_oe = ~parity;
  - edge 10: data_oe=0 (stop bit, line released);
  - edge 11: sample sync_data; ack_ok register = ~sync_data. Go to WAIT_IDLE.
- WAIT_IDLE: when sync_clk=1 and sync_data=1, pulse done for one cycle with ack_ok valid, then go to IDLE. A missing ACK still completes with ack_ok=0; it is not an error.
- Timeout: the counter runs in SEND and WAIT_IDLE. At TIMEOUT_CYCLES, release both lines, pulse error, leave ack_ok=0, do not pulse done, and go to IDLE.
- done and error are never asserted in the same cycle.
- tx_valid asserted in the done cycle is accepted on the next cycle, in IDLE.
- Edges seen in IDLE, INHIBIT or SETUP are ignored.
- Counters saturate. Counter widths are $clog2 of the largest parameter plus 1.

Decomposition:
- Shared package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, SETUP, SEND, WAIT_IDLE);
  - constants FRAME_EDGES=11 and STOP_EDGE=10;
  - command constants CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, CMD_SET_LEDS=8'hED, ACK_BYTE=8'hFA.
- One sub-module, ps2_line_sync: 2-FF synchroniser plus falling-edge detect for clk and data. The receiver reuses it.

Test Plan:
Run with INHIBIT_CYCLES=100, SETUP_CYCLES=10, TIMEOUT_CYCLES=5000. The device model drives clk at 50-cycle half-periods and samples data on rising edges.
- Send 0xF4 -> device samples start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1; device ACK -> done=1, ack_ok=1, busy falls the cycle after done.
- Send 0x00 and 0xFF -> parity bits sampled are 1 and 1; the frame is otherwise correct.
- Inhibit timing -> ps2_clk_oe high for exactly 100 cycles, then 10 cycles of clk_oe=1 with data_oe=1, then clk_oe=0.
- Device leaves data high at edge 11 -> done pulse, ack_ok=0, error=0.
- Device never clocks -> error pulses 5000 cycles after clk release; both oe=0; tx_ready=1 next cycle; done never asserted.
- Reset low after edge 5 -> both oe=0 immediately; after reset release tx_ready=1; a new 0xFF send completes normally.
